systolic_ctrl: RTL

- Sequencing controller for the output-stationary systolic array of multiply-accumulate PEs.
- Accepts a start command with a reduction length K.
- Issues one clear cycle to the PE grid (drives the PE load_weights/clear pin), then runs the array for the skewed compute window.
- Generates per-row and per-column feed-valid masks plus a shared skew counter for the edge feeders, honours a stall from the input buffers, and signals when accumulated results in every PE are final.

---
 rtl/systolic_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// Sequencer for an output-stationary systolic MAC array:
// one clear cycle, then a skewed compute window with feeder masks.
module systolic_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int K_MAX = 255,
    parameter int KW    = $clog2(K_MAX + 1),
    parameter int CW    = $clog2(K_MAX + ROWS + COLS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            abort,
    input  logic            stall,
    output logic            busy,
    output logic            pe_clear,
    output logic            pe_compute_en,
    output logic [CW-1:0]   cyc,
    output logic [ROWS-1:0] row_valid,
    output logic [COLS-1:0] col_valid,
    output logic            done
);

    localparam int XW = CW + 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cyc_q;
    logic [KW-1:0]   k_q;

    logic [XW-1:0]   cyc_x;
    logic [XW-1:0]   k_x;
    logic [XW-1:0]   last_x;
    logic            advance;

    // Compare in one extra bit so r+k never wraps.
    assign cyc_x   = XW'(cyc_q);
    assign k_x     = XW'(k_q);
    assign last_x  = k_x + XW'(ROWS + COLS - 3);
    assign advance = (state == RUN) && !stall && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cyc_q <= '0;
            k_q   <= '0;
        end else if (abort && (state != IDLE)) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        k_q   <= k_len;
                        cyc_q <= '0;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    cyc_q <= '0;
                    state <= (k_q == '0) ? DONE : RUN;
                end
                RUN: begin
                    if (!stall) begin
                        if (cyc_x == last_x) begin
                            state <= DONE;
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign pe_clear      = (state == CLEAR);
    assign pe_compute_en = advance;
    assign done          = (state == DONE) && !abort;
    assign cyc           = cyc_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row_valid[r] = advance
                           && (cyc_x >= XW'(r))
                           && (cyc_x < (XW'(r) + k_x));
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign col_valid[c] = advance
                           && (cyc_x >= XW'(c))
                           && (cyc_x < (XW'(c) + k_x));
    end

endmodule
